// File: rtl/down_counter_ld.sv
// Loadable synchronous down counter built from T flip-flop stages, with zero flag,
// cascade borrow and a registered done pulse on the 1->0 decrement.
module down_counter_ld #(
    parameter int WIDTH = 2,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             zero,
    output logic             borrow,
    output logic             done
);

    localparam logic WRAP_EN = (WRAP != 0);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] qb_reg;
    logic             done_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t_stage;
    logic             cnt_en;
    logic             done_next;

    assign zero   = ~|q_reg;
    assign borrow = en & ~load & zero & clear;

    // In saturating mode the all-zero state simply stops toggling.
    assign cnt_en    = en & ~load & (WRAP_EN | ~zero);
    assign done_next = cnt_en & (q_reg == WIDTH'(1));

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
            if (gi == 0) begin : g_lsb
                assign t_stage[gi] = cnt_en;
            end else begin : g_upper
                assign t_stage[gi] = cnt_en & ~|q_reg[gi-1:0];
            end
            assign q_next[gi] = load ? d[gi] : (q_reg[gi] ^ t_stage[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!clear) begin
            q_reg    <= '0;
            qb_reg   <= '1;
            done_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            qb_reg   <= ~q_next;
            done_reg <= done_next;
        end
    end

    assign q    = q_reg;
    assign qb   = qb_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_down_counter_ld.sv
// Randomized self-checking bench for down_counter_ld: three instances (2-bit wrap,
// 2-bit saturate, 4-bit wrap) compared against an integer-arithmetic reference model.
module tb_down_counter_ld;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] clear_v;
    logic [2:0] load_v;
    logic [2:0] en_v;
    logic [3:0] d_v [3];

    logic [1:0] q0, qb0, q1, qb1;
    logic [3:0] q2, qb2;
    logic       z0, z1, z2, b0, b1, b2, dn0, dn1, dn2;

    down_counter_ld #(.WIDTH(2), .WRAP(1)) u_w2_wrap (
        .clk(clk), .clear(clear_v[0]), .en(en_v[0]), .load(load_v[0]), .d(d_v[0][1:0]),
        .q(q0), .qb(qb0), .zero(z0), .borrow(b0), .done(dn0)
    );
    down_counter_ld #(.WIDTH(2), .WRAP(0)) u_w2_sat (
        .clk(clk), .clear(clear_v[1]), .en(en_v[1]), .load(load_v[1]), .d(d_v[1][1:0]),
        .q(q1), .qb(qb1), .zero(z1), .borrow(b1), .done(dn1)
    );
    down_counter_ld #(.WIDTH(4), .WRAP(1)) u_w4_wrap (
        .clk(clk), .clear(clear_v[2]), .en(en_v[2]), .load(load_v[2]), .d(d_v[2]),
        .q(q2), .qb(qb2), .zero(z2), .borrow(b2), .done(dn2)
    );

    // Reference model state: count as a plain integer modulo 2^width.
    int m_q    [3];
    int m_done [3];
    int m_mod  [3] = '{4, 4, 16};
    int m_wrap [3] = '{1, 0, 1};

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] oq, oqb;
    logic       oz, ob, od;

    task automatic observe(input int k);
        case (k)
            0: begin oq = {2'b00, q0}; oqb = {2'b00, qb0}; oz = z0; ob = b0; od = dn0; end
            1: begin oq = {2'b00, q1}; oqb = {2'b00, qb1}; oz = z1; ob = b1; od = dn1; end
            default: begin oq = q2; oqb = qb2; oz = z2; ob = b2; od = dn2; end
        endcase
    endtask

    // One clock of stimulus on instance k; the other instances sit idle (hold).
    task automatic step(input int k, input bit c, input bit ld, input bit e, input int dv);
        logic [3:0] exp_q, exp_qb;
        logic       exp_b;
        for (int j = 0; j < 3; j++) begin
            clear_v[j] = 1'b1; load_v[j] = 1'b0; en_v[j] = 1'b0; d_v[j] = 4'd0;
        end
        clear_v[k] = c; load_v[k] = ld; en_v[k] = e; d_v[k] = 4'(dv);
        #1;
        observe(k);
        exp_b = e & ~ld & (m_q[k] == 0) & c;
        n_checks++;
        if (ob !== exp_b) begin
            n_fail++;
            $display("FAIL borrow k=%0d got=%b exp=%b", k, ob, exp_b);
        end
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) if (j != k) m_done[j] = 0;
        if (!c) begin
            m_q[k] = 0; m_done[k] = 0;
        end else if (ld) begin
            m_q[k] = dv % m_mod[k]; m_done[k] = 0;
        end else if (e) begin
            if (m_q[k] != 0) begin
                m_done[k] = (m_q[k] == 1) ? 1 : 0;
                m_q[k] = m_q[k] - 1;
            end else begin
                m_done[k] = 0;
                if (m_wrap[k] != 0) m_q[k] = m_mod[k] - 1;
            end
        end else begin
            m_done[k] = 0;
        end
        observe(k);
        exp_q  = 4'(m_q[k]);
        exp_qb = 4'(m_mod[k] - 1 - m_q[k]);
        $display("step k=%0d clr=%0b ld=%0b en=%0b d=%0d -> q=%0d qb=%0d zero=%0b done=%0b",
                 k, c, ld, e, dv, oq, oqb, oz, od);
        n_checks++;
        if (oq !== exp_q) begin
            n_fail++;
            $display("FAIL q k=%0d got=%0d exp=%0d", k, oq, exp_q);
        end
        n_checks++;
        if (oqb !== exp_qb) begin
            n_fail++;
            $display("FAIL qb k=%0d got=%0d exp=%0d", k, oqb, exp_qb);
        end
        n_checks++;
        if (oz !== (m_q[k] == 0)) begin
            n_fail++;
            $display("FAIL zero k=%0d got=%b exp=%b", k, oz, (m_q[k] == 0));
        end
        n_checks++;
        if (od !== 1'(m_done[k])) begin
            n_fail++;
            $display("FAIL done k=%0d got=%b exp=%0d", k, od, m_done[k]);
        end
    endtask

    task automatic test_reset();
        for (int j = 0; j < 3; j++) begin
            clear_v[j] = 1'b0; load_v[j] = 1'b1; en_v[j] = 1'b1; d_v[j] = 4'd2;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            m_q[j] = 0; m_done[j] = 0;
            observe(j);
            $display("reset k=%0d q=%0d qb=%0d done=%0b", j, oq, oqb, od);
            n_checks++;
            if (oq !== 4'd0 || oqb !== 4'(m_mod[j] - 1) || od !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state k=%0d got q=%0d qb=%0d done=%b exp q=0 qb=%0d done=0",
                         j, oq, oqb, od, m_mod[j] - 1);
            end
        end
        step(0, 1'b0, 1'b1, 1'b1, 2);
        step(0, 1'b0, 1'b1, 1'b1, 2);
    endtask

    task automatic test_wrap_count();
        step(0, 1'b1, 1'b1, 1'b0, 3);
        repeat (5) step(0, 1'b1, 1'b0, 1'b1, 0);
    endtask

    task automatic test_saturate();
        step(1, 1'b1, 1'b1, 1'b0, 1);
        repeat (4) step(1, 1'b1, 1'b0, 1'b1, 0);
    endtask

    task automatic test_load_priority();
        step(0, 1'b1, 1'b1, 1'b0, 3);
        step(0, 1'b1, 1'b1, 1'b1, 1);
        repeat (2) step(0, 1'b1, 1'b0, 1'b0, 0);
        step(0, 1'b1, 1'b1, 1'b1, 0);
    endtask

    task automatic test_mid_reset();
        step(0, 1'b1, 1'b1, 1'b0, 2);
        step(0, 1'b0, 1'b0, 1'b1, 0);
        step(0, 1'b1, 1'b1, 1'b0, 0);
        step(0, 1'b1, 1'b0, 1'b1, 0);
    endtask

    task automatic test_width4();
        step(2, 1'b1, 1'b1, 1'b0, 8);
        repeat (10) step(2, 1'b1, 1'b0, 1'b1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 450; i++) begin
            int k;
            k = int'($urandom_range(0, 2));
            step(k, ($urandom_range(0, 15) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        for (int j = 0; j < 3; j++) begin
            clear_v[j] = 1'b0; load_v[j] = 1'b0; en_v[j] = 1'b0; d_v[j] = 4'd0;
            m_q[j] = 0; m_done[j] = 0;
        end
        test_reset();
        test_wrap_count();
        test_saturate();
        test_load_priority();
        test_mid_reset();
        test_width4();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
